// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S receiver: FSM states, output field positions
// and channel codes.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC,
    DELAY,
    SHIFT,
    PAD
  } rx_state_e;

  localparam int unsigned AUD_LSB_POS = 4;
  localparam int unsigned AUD_MSB_POS = 27;
  localparam int unsigned AUD_FIELD_W = AUD_MSB_POS - AUD_LSB_POS + 1;

  localparam logic TID_LEFT  = 1'b0;
  localparam logic TID_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_out_fifo.sv
// Two-entry output FIFO for the I2S receiver; empty/full decode straight from
// the registered occupancy count, so the read side never waits on the pop input.
module i2s_rx_out_fifo
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 35
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_rdata = r_mem[r_rptr];

  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_rd) r_rptr <= ~r_rptr;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receiver: recovers left/right samples from SCLK/LRCLK/SDATA and emits them
// as an AXI4-Stream master. Define I2S_RX_OVF_COUNT_EN to add the ovf_count output.
module i2s_rx_deser
  import i2s_rx_pkg::*;
#(
  parameter int unsigned AUD_WIDTH             = 24,
  parameter int unsigned SLOT_WIDTH            = 32,
  parameter int unsigned AXI_STREAM_DATA_WIDTH = 32,
  parameter int unsigned AXI_STREAM_TID_WIDTH  = 3
) (
  input  logic                             aud_mclk,
  input  logic                             aud_mrst,
  input  logic                             sclk_in,
  input  logic                             lrclk_in,
  input  logic                             sdata_in,
  input  logic                             err_clr,
  output logic                             m_axis_aud_tvalid,
  input  logic                             m_axis_aud_tready,
  output logic [AXI_STREAM_DATA_WIDTH-1:0] m_axis_aud_tdata,
  output logic [AXI_STREAM_TID_WIDTH-1:0]  m_axis_aud_tid,
  output logic                             err_short,
  output logic                             err_ovf
`ifdef I2S_RX_OVF_COUNT_EN
  ,
  output logic [15:0]                      ovf_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam int unsigned FW    = AXI_STREAM_DATA_WIDTH + AXI_STREAM_TID_WIDTH;

  logic [1:0]           r_sclk_q;
  logic [1:0]           r_lr_q;
  logic [1:0]           r_sd_q;
  logic                 w_bit_evt;
  logic                 w_lr;
  logic                 w_sd;
  logic                 w_lr_chg;

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [AUD_WIDTH-1:0] r_shreg;
  logic [AUD_WIDTH-1:0] w_shreg_nxt;
  logic [AUD_WIDTH-1:0] w_word;
  logic                 r_chan;
  logic                 w_chan_nxt;
  logic                 r_lr_prev;
  logic                 w_push;
  logic                 w_short_evt;

  logic                             r_err_short;
  logic                             r_err_ovf;
  logic                             w_ovf_evt;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_pop;
  logic [AXI_STREAM_DATA_WIDTH-1:0] w_tdata;
  logic [AXI_STREAM_TID_WIDTH-1:0]  w_tid;
  logic [FW-1:0]                    w_wdata;
  logic [FW-1:0]                    w_rdata;

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      r_sclk_q <= '0;
      r_lr_q   <= '0;
      r_sd_q   <= '0;
    end else begin
      r_sclk_q <= {r_sclk_q[0], sclk_in};
      r_lr_q   <= {r_lr_q[0], lrclk_in};
      r_sd_q   <= {r_sd_q[0], sdata_in};
    end
  end

  assign w_bit_evt = r_sclk_q[0] & ~r_sclk_q[1];
  assign w_lr      = r_lr_q[1];
  assign w_sd      = r_sd_q[1];
  assign w_lr_chg  = w_lr ^ r_lr_prev;
  assign w_cnt_inc = r_bit_cnt + CNT_W'(1);
  assign w_word    = {r_shreg[AUD_WIDTH-2:0], w_sd};

  // DELAY is "slot opened, waiting for the MSB": the lrclk-change event itself
  // is the discarded delay bit, so the event seen in DELAY is the first data bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_chan_nxt  = r_chan;
    w_push      = 1'b0;
    w_short_evt = 1'b0;
    if (w_bit_evt) begin
      unique case (r_state)
        SYNC, PAD: begin
          if (w_lr_chg) begin
            w_state_nxt = DELAY;
            w_chan_nxt  = w_lr ? TID_RIGHT : TID_LEFT;
            w_cnt_nxt   = '0;
          end
        end
        DELAY, SHIFT: begin
          if (w_lr_chg) begin
            w_short_evt = 1'b1;
            w_state_nxt = DELAY;
            w_chan_nxt  = w_lr ? TID_RIGHT : TID_LEFT;
            w_cnt_nxt   = '0;
          end else begin
            w_shreg_nxt = w_word;
            w_cnt_nxt   = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(AUD_WIDTH)) begin
              w_push      = 1'b1;
              w_state_nxt = PAD;
            end else begin
              w_state_nxt = SHIFT;
            end
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      r_state   <= SYNC;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_chan    <= TID_LEFT;
      r_lr_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_chan    <= w_chan_nxt;
      if (w_bit_evt) r_lr_prev <= w_lr;
    end
  end

  always_comb begin
    w_tdata = '0;
    w_tdata[AUD_MSB_POS:AUD_LSB_POS] = AUD_FIELD_W'(w_word);
    w_tid    = '0;
    w_tid[0] = r_chan;
  end

  assign w_wdata = {w_tdata, w_tid};

  i2s_rx_out_fifo #(
    .DATA_W(FW)
  ) u_out_fifo (
    .i_clk   (aud_mclk),
    .i_rst   (aud_mrst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty)
  );

  assign m_axis_aud_tvalid                  = ~w_empty;
  assign w_pop                              = m_axis_aud_tvalid & m_axis_aud_tready;
  assign {m_axis_aud_tdata, m_axis_aud_tid} = w_rdata;

  assign w_ovf_evt = w_push & w_full & ~w_pop;

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      r_err_short <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_err_short <= w_short_evt | (r_err_short & ~err_clr);
      r_err_ovf   <= w_ovf_evt | (r_err_ovf & ~err_clr);
    end
  end

  assign err_short = r_err_short;
  assign err_ovf   = r_err_ovf;

`ifdef I2S_RX_OVF_COUNT_EN
  logic [15:0] r_ovf_count;

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      r_ovf_count <= '0;
    end else if (w_ovf_evt) begin
      if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + 16'd1;
    end else if (err_clr) begin
      r_ovf_count <= '0;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench for i2s_rx_deser: drives an I2S transmitter model and
// checks the recovered AXI stream and sticky flags.
`timescale 1ns/1ps
module tb_i2s_rx_deser;

  logic        aud_mclk = 1'b0;
  logic        aud_mrst;
  logic        sclk_in;
  logic        lrclk_in;
  logic        sdata_in;
  logic        err_clr;
  logic        m_axis_aud_tvalid;
  logic        m_axis_aud_tready;
  logic [31:0] m_axis_aud_tdata;
  logic [2:0]  m_axis_aud_tid;
  logic        err_short;
  logic        err_ovf;
`ifdef I2S_RX_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  i2s_rx_deser #(
    .AUD_WIDTH(24),
    .SLOT_WIDTH(32),
    .AXI_STREAM_DATA_WIDTH(32),
    .AXI_STREAM_TID_WIDTH(3)
  ) dut (
    .aud_mclk          (aud_mclk),
    .aud_mrst          (aud_mrst),
    .sclk_in           (sclk_in),
    .lrclk_in          (lrclk_in),
    .sdata_in          (sdata_in),
    .err_clr           (err_clr),
    .m_axis_aud_tvalid (m_axis_aud_tvalid),
    .m_axis_aud_tready (m_axis_aud_tready),
    .m_axis_aud_tdata  (m_axis_aud_tdata),
    .m_axis_aud_tid    (m_axis_aud_tid),
    .err_short         (err_short),
    .err_ovf           (err_ovf)
`ifdef I2S_RX_OVF_COUNT_EN
    ,
    .ovf_count         (ovf_count)
`endif
  );

  always #5 aud_mclk = ~aud_mclk;

  int n_vec = 0;
  int n_mis = 0;

  int half        = 4;
  int rst_rel_bit = -1;
  int clr_bit     = -1;
  int lat_bit     = -1;
  int tr_mode     = 0;
  logic tr_val    = 1'b1;

  logic [34:0] got[$];
  logic        stall = 1'b0;
  logic [34:0] hold  = '0;

  typedef struct {
    int          len;
    logic [23:0] smp;
    bit          emit;
    logic [31:0] exp_data;
    logic [2:0]  exp_tid;
    bit          exp_short;
    int          lat;
  } slot_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] exp_word(input logic [23:0] s, input int ch);
    return {32'(s) << 4, 3'(ch)};
  endfunction

  initial begin
    m_axis_aud_tready = 1'b0;
    forever begin
      @(posedge aud_mclk); #1;
      case (tr_mode)
        0:       m_axis_aud_tready = tr_val;
        1:       m_axis_aud_tready = ~m_axis_aud_tready;
        default: m_axis_aud_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge aud_mclk) begin
    if (aud_mrst) begin
      stall = 1'b0;
    end else begin
      if (stall)
        check("axi_stable", {m_axis_aud_tvalid, m_axis_aud_tdata, m_axis_aud_tid}, {1'b1, hold});
      if (m_axis_aud_tvalid && m_axis_aud_tready) got.push_back({m_axis_aud_tdata, m_axis_aud_tid});
      stall = m_axis_aud_tvalid && !m_axis_aud_tready;
      hold  = {m_axis_aud_tdata, m_axis_aud_tid};
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_tvalid"}, m_axis_aud_tvalid, 0);
    check({tag, "_tdata"}, m_axis_aud_tdata, 0);
    check({tag, "_tid"}, m_axis_aud_tid, 0);
    check({tag, "_err_short"}, err_short, 0);
    check({tag, "_err_ovf"}, err_ovf, 0);
`ifdef I2S_RX_OVF_COUNT_EN
    check({tag, "_ovf_count"}, ovf_count, 0);
`endif
  endtask

  task automatic do_reset();
    aud_mrst = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b0; sdata_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge aud_mclk);
    #1;
    check_reset_vals("reset");
    aud_mrst = 1'b0;
    got.delete();
  endtask

  // One I2S slot: bit 0 is the delay bit, bits 1..24 the sample MSB first.
  task automatic send_slot(input logic lr, input int len, input logic [23:0] smp);
    for (int b = 0; b < len; b++) begin
      logic bitv;
      if (b >= 1 && b <= 24) bitv = smp[24-b];
      else bitv = 1'($urandom_range(0, 1));
      sclk_in = 1'b0; lrclk_in = lr; sdata_in = bitv;
      for (int c = 0; c < half; c++) begin
        @(posedge aud_mclk); #1;
        if (b == rst_rel_bit && c == 0) aud_mrst = 1'b0;
      end
      sclk_in = 1'b1;
      for (int c = 0; c < half; c++) begin
        @(posedge aud_mclk); #1;
        if (b == clr_bit) err_clr = (c == 0);
        if (b == lat_bit && c == 0) check("latency_pre", m_axis_aud_tvalid, 0);
        if (b == lat_bit && c == 1) check("latency_post", m_axis_aud_tvalid, 1);
      end
    end
    sclk_in = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(posedge aud_mclk);
    @(posedge aud_mclk); #1;
    check("word_count", got.size(), n);
  endtask

  task automatic compare_words(input string tag, input logic [34:0] expq[$]);
    for (int i = 0; i < expq.size(); i++)
      check(tag, (i < got.size()) ? 64'(got[i]) : 64'hDEAD_DEAD_DEAD_DEAD, expq[i]);
  endtask

  task automatic run_random(input int nslots, input int hf, input int trm);
    logic [34:0] expq[$];
    bit          exp_short = 0;
    int          lens[];
    logic [23:0] smps[];
    lens = new[nslots];
    smps = new[nslots];
    for (int i = 0; i < nslots; i++) begin
      lens[i] = (i > 0 && trm == 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(2, 24))
                                                                  : int'($urandom_range(25, 40));
      if (trm != 2) lens[i] = 32;
      smps[i] = 24'($urandom);
    end
    // A slot yields a word iff it carries the delay bit plus 24 data bits;
    // a shorter slot flags err_short once the following slot starts.
    for (int i = 1; i < nslots; i++) begin
      if (lens[i] >= 25) expq.push_back(exp_word(smps[i], i % 2));
      else if (i < nslots - 1) exp_short = 1;
    end
    do_reset();
    half = hf; tr_mode = trm;
    for (int i = 0; i < nslots; i++) send_slot(1'(i % 2), lens[i], smps[i]);
    wait_words(expq.size(), 200);
    compare_words("rand_word", expq);
    check("rand_err_short", err_short, exp_short);
    check("rand_err_ovf", err_ovf, 0);
    tr_mode = 0;
  endtask

  initial begin
    slot_vec_t   tbl[8];
    logic [34:0] expq[$];

    tbl[0] = '{32, 24'h000000, 0, 32'h00000000, 3'd0, 0, -1};
    tbl[1] = '{32, 24'h000001, 1, 32'h00000010, 3'd1, 0, -1};
    tbl[2] = '{32, 24'hA5A5A5, 1, 32'h0A5A5A50, 3'd0, 0, 24};
    tbl[3] = '{32, 24'h5A5A5A, 1, 32'h05A5A5A0, 3'd1, 0, -1};
    tbl[4] = '{21, 24'hDEADBE, 0, 32'h00000000, 3'd0, 0, -1};
    tbl[5] = '{32, 24'h123456, 1, 32'h01234560, 3'd1, 1, -1};
    tbl[6] = '{40, 24'hFFFFFF, 1, 32'h0FFFFFF0, 3'd0, 1, -1};
    tbl[7] = '{25, 24'h800001, 1, 32'h08000010, 3'd1, 1, -1};

    // Table-driven stream with tready held high.
    tr_mode = 0; tr_val = 1'b1; half = 4;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      lat_bit = tbl[i].lat;
      send_slot(1'(i % 2), tbl[i].len, tbl[i].smp);
      lat_bit = -1;
      check("tbl_err_short", err_short, tbl[i].exp_short);
      if (tbl[i].emit) expq.push_back({tbl[i].exp_data, tbl[i].exp_tid});
    end
    wait_words(expq.size(), 200);
    compare_words("tbl_word", expq);
    check("tbl_err_ovf", err_ovf, 0);

    // Reset released part-way through a left slot.
    aud_mrst = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge aud_mclk);
    #1;
    got.delete();
    rst_rel_bit = 10;
    send_slot(1'b0, 32, 24'h0);
    rst_rel_bit = -1;
    send_slot(1'b1, 32, 24'hC0FFEE);
    send_slot(1'b0, 32, 24'h13579B);
    wait_words(2, 200);
    expq.delete();
    expq.push_back(exp_word(24'hC0FFEE, 1));
    expq.push_back(exp_word(24'h13579B, 0));
    compare_words("midrst_word", expq);
    check("midrst_err_short", err_short, 0);

    // Overflow with tready low for four slots, then drain.
    tr_val = 1'b0;
    do_reset();
    send_slot(1'b0, 32, 24'h0);
    send_slot(1'b1, 32, 24'h111111);
    send_slot(1'b0, 32, 24'h222222);
    send_slot(1'b1, 32, 24'h333333);
    send_slot(1'b0, 32, 24'h444444);
    check("ovf_none_out", got.size(), 0);
    check("ovf_err_ovf", err_ovf, 1);
    check("ovf_hold_word", {m_axis_aud_tvalid, m_axis_aud_tdata, m_axis_aud_tid},
          {1'b1, exp_word(24'h111111, 1)});
`ifdef I2S_RX_OVF_COUNT_EN
    check("ovf_count", ovf_count, 2);
`endif
    tr_val = 1'b1;
    wait_words(2, 50);
    expq.delete();
    expq.push_back(exp_word(24'h111111, 1));
    expq.push_back(exp_word(24'h222222, 0));
    compare_words("ovf_drain", expq);
    check("ovf_sticky", err_ovf, 1);
    check("ovf_err_short", err_short, 0);

    err_clr = 1'b1;
    @(posedge aud_mclk); #1;
    err_clr = 1'b0;
    check("clr_err_ovf", err_ovf, 0);
`ifdef I2S_RX_OVF_COUNT_EN
    check("clr_ovf_count", ovf_count, 0);
`endif

    // err_clr in the same cycle as a fresh overflow: the set must win.
    tr_val = 1'b0;
    send_slot(1'b1, 32, 24'h555555);
    send_slot(1'b0, 32, 24'h666666);
    clr_bit = 24;
    send_slot(1'b1, 32, 24'h777777);
    clr_bit = -1;
    err_clr = 1'b0;
    check("clr_vs_ovf", err_ovf, 1);

    // Reset mid-operation with a full buffer.
    aud_mrst = 1'b1;
    @(posedge aud_mclk); #1;
    check_reset_vals("midop_rst");
    aud_mrst = 1'b0;
    tr_val = 1'b1;
    repeat (20) @(posedge aud_mclk);
    #1;
    check("midop_flushed", got.size(), 2);

    // 16 frames with tready toggling every cycle, then random traffic.
    run_random(33, 4, 1);
    for (int r = 0; r < 3; r++) run_random(12, int'($urandom_range(2, 4)), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

I2S receiver/deserializer that sits directly downstream of the I2S transmitter serial outputs. It recovers 24-bit left/right samples from the SCLK/LRCLK/SDATA triple and re-emits them as an AXI4-Stream master in the same sample format the transmitter consumes. Used as a loop-back stage so transmitted audio can be compared word-for-word against the stream that fed the transmitter.

## Interface
- AUD_WIDTH, 24: audio sample width captured per channel slot.
- SLOT_WIDTH, 32: SCLK periods per channel slot (LRCLK half-period); must be ≥ AUD_WIDTH+1.
- AXI_STREAM_DATA_WIDTH, 32: m_axis_aud_tdata width.
- AXI_STREAM_TID_WIDTH, 3: m_axis_aud_tid width.
- aud_mclk  in  1  audio master clock; all logic on its rising edge.
- aud_mrst  in  1  reset; synchronous, active-high.
- sclk_in  in  1  serial bit clock, generated in the aud_mclk domain.
- lrclk_in  in  1  word select; 0 = left, 1 = right.
- sdata_in  in  1  serial data, MSB first, I2S one-bit delay.
- err_clr  in  1  single-cycle pulse clearing the sticky flags.
- m_axis_aud_tvalid  out  1  output word valid.
- m_axis_aud_tready  in  1  downstream ready.
- m_axis_aud_tdata  out  32  sample at [27:4]; [31:28] and [3:0] zero.
- m_axis_aud_tid  out  3  0 = left, 1 = right; bits [2:1] zero.
- err_short  out  1  sticky: a slot ended before AUD_WIDTH bits were captured.
- err_ovf  out  1  sticky: a completed word was dropped because the buffer was full.

## Operation
- Input stage: sclk_in, lrclk_in and sdata_in are each registered twice. A bit event (sclk rise) is q1 & ~q2 of sclk; lrclk and sdata are taken from the q2 stage on that cycle.
- All state below advances only on bit events.
- State machine:
  - SYNC: entered from reset. On the first bit event where lrclk differs from lr_prev, go to DELAY.
  - DELAY: the current bit is the delay bit and is discarded. Latch chan = lrclk and set bit_cnt = 0. The next bit event goes to SHIFT.
  - SHIFT: shift sdata into shreg MSB-first and increment bit_cnt. When bit_cnt reaches AUD_WIDTH, push the word and go to PAD.
  - PAD: ignore bits. An lrclk change goes to DELAY for the next slot.
- An lrclk change while in SHIFT sets err_short, discards the partial word and restarts DELAY on that same event.
- A slot longer than SLOT_WIDTH is not an error; extra bits are absorbed in PAD.
- lr_prev updates on every bit event in every state.
- Output buffer is a 2-entry FIFO:
  - A push when full and with no same-cycle pop is dropped and sets err_ovf.
  - A push and pop in the same cycle when full are both accepted.
- Sticky flags: err_clr clears them. If an error event and err_clr occur in the same cycle, the set wins.

## Timing
- Reset values: tvalid, tdata, tid, err_short, err_ovf all 0; state SYNC; FIFO empty; bit_cnt, shreg, lr_prev 0.
- Pin-to-event latency: 2 aud_mclk cycles from the sclk_in rise to the bit event.
- Push-to-output: tvalid rises 1 cycle after the cycle in which the final (AUD_WIDTH-th) bit event occurs, provided the FIFO was empty.
- AXI rules:
  - tdata and tid stay stable while tvalid=1 and tready=0.
  - tvalid does not depend combinationally on tready.
  - Back-to-back transfers are supported at 1 word per cycle.
- Reset mid-operation: aud_mrst has priority over everything. The partial word and FIFO contents are lost, and the next cycle matches the reset values.
- Minimum SCLK period: 4 aud_mclk cycles (high ≥ 2 cycles, low ≥ 2 cycles).

## Configuration
- I2S_RX_OVF_COUNT_EN:
  - Defined: adds output ovf_count [15:0]. It increments on every dropped word, saturates at 16'hFFFF, clears on err_clr or reset, and its reset value is 0.
  - Undefined: the port and counter are absent; err_ovf behaviour is unchanged.

## Structure
- Shared package i2s_rx_pkg holds:
  - rx_state_e enum (SYNC, DELAY, SHIFT, PAD).
  - Constants AUD_LSB_POS = 4 and AUD_MSB_POS = 27.
  - Channel codes TID_LEFT = 0 and TID_RIGHT = 1.
- Sub-module i2s_rx_out_fifo: 2-entry FIFO with registered valid. Data width is AXI_STREAM_DATA_WIDTH + AXI_STREAM_TID_WIDTH. Ports: push/full/pop/empty.

## Test plan
- Left 24'hA5A5A5, right 24'h5A5A5A, SCLK_DIV=8, SLOT_WIDTH=32, tready=1 -> tdata 32'h0A5A5A50 with tid 0, then 32'h05A5A5A0 with tid 1; no flags set.
- Reset deasserted mid-slot -> no word emitted until the first complete slot after an lrclk edge; the first word out carries the correct tid.
- lrclk toggled after 20 bits -> err_short=1, partial word dropped; the next full slot (value 24'h123456) -> tdata 32'h01234560.
- tready=0 for 4 slots -> 2 words buffered, 2 dropped, err_ovf=1 (ovf_count=2 with I2S_RX_OVF_COUNT_EN). Releasing tready drains the first two words in order.
- err_clr pulsed on the same cycle as a new overflow -> err_ovf stays 1. err_clr alone -> 0 on the next cycle.
- tready toggling every cycle across 16 frames -> all 32 words received in order, no flags set, tdata stable whenever tvalid=1 and tready=0.
